// File: rtl/downscaler_pkg.sv
// downscaler_pkg: shared types and constants for the streaming pyramid downscaler.
package downscaler_pkg;

    localparam int DEFAULT_FRAC_BITS = 16;
    localparam int CFG_STEP_W        = 32;
    localparam int CFG_DIM_W         = 16;
    localparam logic [CFG_STEP_W-1:0] ONE_FP = CFG_STEP_W'(1) << DEFAULT_FRAC_BITS;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [CFG_STEP_W-1:0] step;
        logic [CFG_DIM_W-1:0]  out_width;
        logic [CFG_DIM_W-1:0]  out_height;
    } cfg_t;

    // Steps below 1.0 would upscale; they are forced to exactly 1.0.
    function automatic logic [CFG_STEP_W-1:0] clamp_step(input logic [CFG_STEP_W-1:0] s, input int frac);
        logic [CFG_STEP_W-1:0] one;
        one = CFG_STEP_W'(1) << frac;
        return (s < one) ? one : s;
    endfunction

endpackage

// File: rtl/ds_axis_tracker.sv
// ds_axis_tracker: one axis of the decimator -- source index, fixed-point
// accumulator and output index, reporting whether the current source index is taken.
module ds_axis_tracker
    import downscaler_pkg::*;
#(
    parameter int N         = 40,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
    localparam int IW = $clog2(N),
    localparam int OW = $clog2(N + 1),
    localparam int AW = IW + FRAC_BITS + 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  advance,
    input  logic                  step_en,
    input  logic [CFG_STEP_W-1:0] step,
    input  logic [CFG_DIM_W-1:0]  limit,
    output logic [IW-1:0]         idx,
    output logic [OW-1:0]         out_idx,
    output logic                  hit
);

    logic [AW-1:0] acc;
    logic          last;

    assign last = idx == IW'(N - 1);
    assign hit  = (acc[AW-1:FRAC_BITS] == {1'b0, idx}) && (CFG_DIM_W'(out_idx) < limit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            out_idx <= '0;
            acc     <= '0;
        end else if (clear) begin
            idx     <= '0;
            out_idx <= '0;
            acc     <= '0;
        end else begin
            if (advance) idx <= last ? '0 : idx + 1'b1;
            // Wrapping the source index restarts the axis; it outranks a same-cycle step.
            if (advance && last) begin
                acc     <= '0;
                out_idx <= '0;
            end else if (step_en) begin
                acc     <= acc + AW'(step);
                out_idx <= out_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pyramid_stream_downscaler.sv
// pyramid_stream_downscaler: streaming nearest-neighbour frame decimator.
// Optional DOWNSCALER_FRAME_CHECK_EN adds in_sof/in_eol framing checks with a sticky frame_err.
module pyramid_stream_downscaler
    import downscaler_pkg::*;
#(
    parameter int SRC_WIDTH     = 40,
    parameter int SRC_HEIGHT    = 30,
    parameter int PIXEL_W       = 8,
    parameter int FRAC_BITS     = DEFAULT_FRAC_BITS,
    parameter int STEP_INT_BITS = 8
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [STEP_INT_BITS+FRAC_BITS-1:0]  cfg_step,
    input  logic [$clog2(SRC_WIDTH+1)-1:0]      cfg_out_width,
    input  logic [$clog2(SRC_HEIGHT+1)-1:0]     cfg_out_height,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PIXEL_W-1:0]                  in_data,
`ifdef DOWNSCALER_FRAME_CHECK_EN
    input  logic                                in_sof,
    input  logic                                in_eol,
    output logic                                frame_err,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PIXEL_W-1:0]                  out_data,
    output logic                                out_eol,
    output logic                                out_eof,
    output logic                                busy,
    output logic                                done
);

    localparam int XW = $clog2(SRC_WIDTH);
    localparam int YW = $clog2(SRC_HEIGHT);
    localparam int XO = $clog2(SRC_WIDTH + 1);
    localparam int YO = $clog2(SRC_HEIGHT + 1);

    state_t          state, state_nx;
    cfg_t            cfg_q, cfg_d;
    logic [XW-1:0]   src_x;
    logic [YW-1:0]   src_y;
    logic [XO-1:0]   out_x;
    logic [YO-1:0]   out_y;
    logic            x_last, y_last, x_hit, y_hit;
    logic            clear, accepted, keep, row_end, eol_nx, eof_nx;

    assign cfg_d    = '{step:       clamp_step(CFG_STEP_W'(cfg_step), FRAC_BITS),
                        out_width:  CFG_DIM_W'(cfg_out_width),
                        out_height: CFG_DIM_W'(cfg_out_height)};
    assign clear    = (state == IDLE) && start;
    assign accepted = in_valid && in_ready;
    assign keep     = accepted && x_hit && y_hit;
    assign x_last   = src_x == XW'(SRC_WIDTH - 1);
    assign y_last   = src_y == YW'(SRC_HEIGHT - 1);
    assign row_end  = accepted && x_last;
    assign eol_nx   = CFG_DIM_W'(out_x) + 1'b1 == cfg_q.out_width;
    assign eof_nx   = eol_nx && (CFG_DIM_W'(out_y) + 1'b1 == cfg_q.out_height);

    ds_axis_tracker #(.N(SRC_WIDTH), .FRAC_BITS(FRAC_BITS)) u_x (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .advance (accepted),
        .step_en (keep),
        .step    (cfg_q.step),
        .limit   (cfg_q.out_width),
        .idx     (src_x),
        .out_idx (out_x),
        .hit     (x_hit)
    );

    ds_axis_tracker #(.N(SRC_HEIGHT), .FRAC_BITS(FRAC_BITS)) u_y (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .advance (row_end),
        .step_en (row_end && y_hit),
        .step    (cfg_q.step),
        .limit   (cfg_q.out_height),
        .idx     (src_y),
        .out_idx (out_y),
        .hit     (y_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (row_end && y_last) state_nx = FLUSH;
            FLUSH: if (!out_valid || out_ready) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN) && (!out_valid || out_ready);
        busy     = (state == RUN) || (state == FLUSH);
        done     = state == DONE;
    end

    // in_ready already guarantees room, so a kept pixel may overwrite a departing one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (clear) cfg_q <= cfg_d;
            if (keep) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_eol   <= eol_nx;
                out_eof   <= eof_nx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DOWNSCALER_FRAME_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame_err <= 1'b0;
        else if (clear)
            frame_err <= 1'b0;
        else if (accepted && ((in_sof && (src_x != '0 || src_y != '0)) || (in_eol != x_last)))
            frame_err <= 1'b1;
    end
`endif

endmodule

// File: doc/pyramid_stream_downscaler.md
Name: pyramid_stream_downscaler

Overview:
- Streaming, sequential successor to the combinational pyramid-level downscaler.
- Consumes one source frame in raster order, one 8-bit pixel per handshake, and emits the nearest-neighbour decimated image for a runtime-programmable scale step.
- Source coordinates are generated with fixed-point accumulators, not per-level mapping tables.
- Sits between the frame buffer reader and the integral-image builder; one instance serves every pyramid level.

Parameters:
- SRC_WIDTH, 40, source frame width in pixels
- SRC_HEIGHT, 30, source frame height in pixels
- PIXEL_W, 8, pixel data width
- FRAC_BITS, 16, fractional bits of the scale step
- STEP_INT_BITS, 8, integer bits of the scale step

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin frame; cfg_* sampled this cycle
- cfg_step  in  STEP_INT_BITS+FRAC_BITS  source pixels per output pixel, unsigned fixed point
- cfg_out_width  in  $clog2(SRC_WIDTH+1)  output columns
- cfg_out_height  in  $clog2(SRC_HEIGHT+1)  output rows
- in_valid / in_ready  in / out  1  source pixel handshake
- in_data  in  PIXEL_W  source pixel
- out_valid / out_ready  out / in  1  output pixel handshake
- out_data  out  PIXEL_W  output pixel
- out_eol  out  1  last pixel of an output row
- out_eof  out  1  last pixel of the output frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_eol=0, out_eof=0, busy=0, done=0, in_ready=0; FSM in IDLE.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on start. Latches cfg_*, clears src_x, src_y, out_x, out_y and both accumulators to 0.
  - RUN→FLUSH when the source pixel (SRC_WIDTH-1, SRC_HEIGHT-1) is accepted.
  - FLUSH→DONE once the output register is empty (out_valid=0 or out_ready=1 this cycle).
  - DONE→IDLE unconditionally. done=1 only in DONE.
- start outside IDLE is ignored. busy=1 in RUN and FLUSH.
- in_ready = (state==RUN) && (!out_valid || out_ready). Every source pixel is consumed, whether kept or dropped.
- Accumulators:
  - acc_x and acc_y are unsigned, $clog2(SRC_*)+FRAC_BITS+1 bits wide.
  - A column hits when acc_x[int] == src_x and out_x < cfg_out_width.
  - A row hits when acc_y[int] == src_y and out_y < cfg_out_height.
  - A pixel is kept when both hit.
- On a kept pixel:
  - Load out_data and set out_valid at the next edge (latency 1 cycle).
  - acc_x += step, out_x++.
  - out_eol = (out_x == cfg_out_width-1).
  - out_eof = out_eol && (out_y == cfg_out_height-1).
- At the end of each source row (src_x wraps from SRC_WIDTH-1 to 0):
  - acc_x and out_x are cleared.
  - If the row hit: acc_y += step, out_y++.
- step clamp: cfg_step < 1.0 (1<<FRAC_BITS) is treated as exactly 1.0. Upscaling is not supported.
- out_width or out_height of 0: no output is produced; the frame is consumed and done still pulses.
- Rows and columns beyond cfg_out_height / cfg_out_width are consumed and dropped.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_eol and out_eof hold stable and in_ready=0.
- Simultaneous output accept and new kept pixel in the same cycle: the register reloads with no bubble.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded.

Optional Feature:
- Macro: DOWNSCALER_FRAME_CHECK_EN.
- Defined:
  - Adds inputs in_sof and in_eol.
  - Adds output frame_err, a sticky bit cleared on start.
  - frame_err sets if in_sof is asserted on an accepted pixel with (src_x,src_y)≠(0,0).
  - frame_err sets if in_eol disagrees with (src_x==SRC_WIDTH-1) on an accepted pixel.
  - Data flow is unaffected.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package downscaler_pkg:
  - FRAC_BITS default and ONE_FP constant
  - state enum (IDLE, RUN, FLUSH, DONE)
  - packed cfg struct (step, out_width, out_height)
- Sub-module ds_axis_tracker, instantiated twice (x, y). Contents:
  - source index counter with wrap
  - accumulator
  - output index counter
  - hit output
  - advance input and clear input

Test Plan:
- SRC 8x6, in_data=y*8+x, step 0x10000, out 8x6 → 48 outputs equal to the inputs; eol on each x=7; eof on the last output; done pulses once.
- step 0x20000, out 4x3 → outputs 0,2,4,6,16,18,…,38,…; 12 pixels total.
- step 0x14000, out 6x4 → row 0 outputs 0,1,2,3,5,6 (source x=7 dropped); rows taken from y=0,1,2,3.
- Hold out_ready=0 for 5 cycles mid-row → out_data/out_eol stable, in_ready=0, no pixels lost or duplicated.
- Assert reset_n=0 after 20 pixels, then start a new frame → outputs are reset values, then the new frame is correct from pixel 0.
- cfg_step=0x08000 plus a start pulse during RUN → treated as step 1.0; the second start is ignored, busy stays 1, a single done pulse.
